// File: rtl/alu_pkg.sv
// Shared types and constants for the multicycle ALU.
//   alu_op_t    : 3-bit operation encodings on the op port
//   alu_state_t : sequencing FSM states
//   FLAG_*      : bit positions inside flags[3:0] = {N,Z,C,V}
//   flag_w_for  : flag-register write enables for a completed op
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_ORR = 3'b011,
    OP_EOR = 3'b100,
    OP_MUL = 3'b101,
    OP_LSL = 3'b110,
    OP_RSV = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MUL,
    ST_DONE
  } alu_state_t;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // [1] updates N/Z, [0] updates C/V; only arithmetic ops produce meaningful C/V.
  function automatic logic [1:0] flag_w_for(input alu_op_t op, input logic set_flags);
    logic [1:0] fw;
    fw = 2'b00;
    if (set_flags) begin
      fw = ((op == OP_ADD) || (op == OP_SUB)) ? 2'b11 : 2'b10;
    end
    return fw;
  endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier datapath, sequenced by multicycle_alu.
//   clk, rst   : clock, synchronous active-low reset
//   load       : capture multiplicand/multiplier, clear accumulator and counter
//   step       : perform one shift-add iteration
//   mcand_in   : multiplicand (operand A)
//   mplier_in  : multiplier (operand B)
//   acc        : low WIDTH bits of the running product
//   last       : WIDTH iterations have been performed
module mul_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] mcand_in,
  input  logic [WIDTH-1:0] mplier_in,
  output logic [WIDTH-1:0] acc,
  output logic             last
);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (load) begin
      mcand_d  = mcand_in;
      mplier_d = mplier_in;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (step) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign acc  = acc_q;
  assign last = (cnt_q == CNT_W'(WIDTH));

endmodule

// File: rtl/multicycle_alu.sv
// Execution-stage ALU feeding the flags register.
//   clk, rst  : clock, synchronous active-low reset
//   start     : operation request, accepted only when idle
//   op        : operation select (see alu_op_t); 111 behaves as AND
//   a, b      : operands
//   set_flags : request a flag update for this operation
//   busy      : operation in progress
//   done      : one-cycle completion pulse
//   result    : WIDTH-bit result, held until the next completion
//   flags     : {N,Z,C,V}, held like result
//   flag_w    : flag write enables, nonzero only alongside done
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             set_flags,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic [1:0]       flag_w
);

  localparam int unsigned MSB  = WIDTH - 1;
  localparam int unsigned SH_W = (WIDTH < 5) ? WIDTH : 5;

  alu_state_t state_q, state_d;

  alu_op_t          op_in;
  alu_op_t          op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sf_q, sf_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             c_q, c_d;
  logic             v_q, v_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic [1:0]       flag_w_q, flag_w_d;

  logic             accept;
  logic             mul_load;
  logic             mul_step;
  logic             mul_last;
  logic [WIDTH-1:0] mul_acc;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] exec_res;
  logic             exec_c;
  logic             exec_v;
  logic [WIDTH-1:0] fin_res;

  assign op_in = alu_op_t'(op);

  mul_iter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_mul (
    .clk      (clk),
    .rst      (rst),
    .load     (mul_load),
    .step     (mul_step),
    .mcand_in (a),
    .mplier_in(b),
    .acc      (mul_acc),
    .last     (mul_last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = (op_in == OP_MUL) ? ST_MUL : ST_EXEC;
      ST_EXEC: state_d = ST_DONE;
      ST_MUL:  if (mul_last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM control outputs. busy/done are registered and trail the state by
  // one cycle, so the cycle in which done is high is spent in IDLE; the
  // !done_q term keeps a start seen during that pulse from being accepted.
  always_comb begin
    accept   = (state_q == ST_IDLE) && start && !done_q;
    mul_load = accept && (op_in == OP_MUL);
    mul_step = (state_q == ST_MUL) && !mul_last;
  end

  // Single-cycle operations on the latched operands
  always_comb begin
    sum_ext  = '0;
    exec_res = a_q & b_q;
    exec_c   = 1'b0;
    exec_v   = 1'b0;
    case (op_q)
      OP_ADD: begin
        sum_ext  = {1'b0, a_q} + {1'b0, b_q};
        exec_res = sum_ext[MSB:0];
        exec_c   = sum_ext[WIDTH];
        exec_v   = (a_q[MSB] == b_q[MSB]) && (exec_res[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        sum_ext  = {1'b0, a_q} - {1'b0, b_q};
        exec_res = sum_ext[MSB:0];
        exec_c   = ~sum_ext[WIDTH];
        exec_v   = (a_q[MSB] != b_q[MSB]) && (exec_res[MSB] != a_q[MSB]);
      end
      OP_ORR:  exec_res = a_q | b_q;
      OP_EOR:  exec_res = a_q ^ b_q;
      OP_LSL:  exec_res = a_q << b_q[SH_W-1:0];
      default: exec_res = a_q & b_q;
    endcase
  end

  // Operand capture, execute staging and output update
  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    sf_d     = sf_q;
    res_d    = res_q;
    c_d      = c_q;
    v_d      = v_q;
    result_d = result_q;
    flags_d  = flags_q;
    flag_w_d = 2'b00;
    busy_d   = (state_q == ST_EXEC) || (state_q == ST_MUL);
    done_d   = (state_q == ST_DONE);
    fin_res  = (op_q == OP_MUL) ? mul_acc : res_q;

    if (accept) begin
      op_d  = op_in;
      a_d   = a;
      b_d   = b;
      sf_d  = set_flags;
      // C/V cleared here so MUL, which skips EXEC, completes with C=V=0.
      res_d = '0;
      c_d   = 1'b0;
      v_d   = 1'b0;
    end

    if (state_q == ST_EXEC) begin
      res_d = exec_res;
      c_d   = exec_c;
      v_d   = exec_v;
    end

    if (state_q == ST_DONE) begin
      result_d        = fin_res;
      flags_d[FLAG_N] = fin_res[MSB];
      flags_d[FLAG_Z] = (fin_res == '0);
      flags_d[FLAG_C] = c_q;
      flags_d[FLAG_V] = v_q;
      flag_w_d        = flag_w_for(op_q, sf_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      sf_q     <= 1'b0;
      res_q    <= '0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      flag_w_q <= '0;
    end else begin
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sf_q     <= sf_d;
      res_q    <= res_d;
      c_q      <= c_d;
      v_q      <= v_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      flag_w_q <= flag_w_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign flags  = flags_q;
  assign flag_w = flag_w_q;

endmodule

// File: tb/tb_multicycle_alu.sv
module tb_multicycle_alu;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         set_flags;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic [1:0]   flag_w;

  int total = 0;
  int bad   = 0;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .set_flags(set_flags),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .flags    (flags),
    .flag_w   (flag_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present a request for exactly one rising edge (edge k), return #1 after it.
  task automatic start_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic sf);
    @(negedge clk);
    op = o; a = x; b = y; set_flags = sf; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Run one op to completion and check latency, busy length, outputs and hold.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic sf, input int exp_lat,
                        input logic [W-1:0] exp_res, input logic [3:0] exp_fl,
                        input logic [1:0] exp_fw);
    int n, busy_n, fw_bad;
    n = 0; busy_n = 0; fw_bad = 0;
    start_op(o, x, y, sf);
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (busy) busy_n++;
      if (!done && flag_w != 2'b00) fw_bad++;
    end
    check({tag, "_lat"},    W'(n), W'(exp_lat));
    check({tag, "_busy"},   W'(busy_n), W'(exp_lat - 1));
    check({tag, "_res"},    result, exp_res);
    check({tag, "_flags"},  W'(flags), W'(exp_fl));
    check({tag, "_fw"},     W'(flag_w), W'(exp_fw));
    check({tag, "_fw_idle"}, W'(fw_bad), W'(0));
    @(posedge clk); #1;
    check({tag, "_pulse"},  W'(done), W'(0));
    check({tag, "_hold"},   result, exp_res);
    check({tag, "_fwoff"},  W'(flag_w), W'(0));
  endtask

  initial begin
    int n, dones;
    logic [W-1:0] seen;

    rst = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; set_flags = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",   W'(busy), W'(0));
    check("rst_done",   W'(done), W'(0));
    check("rst_result", result, W'(0));
    check("rst_flags",  W'(flags), W'(0));
    check("rst_fw",     W'(flag_w), W'(0));
    rst = 1'b1;
    @(posedge clk); #1;

    run_op("add_carry", OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 2,  32'h0000_0000, 4'b0110, 2'b11);
    run_op("add_ovf",   OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 2,  32'h8000_0000, 4'b1001, 2'b11);
    run_op("sub_ovf",   OP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b1, 2,  32'h7FFF_FFFF, 4'b0011, 2'b11);
    run_op("sub_neg",   OP_SUB, 32'd5,         32'd7,         1'b1, 2,  32'hFFFF_FFFE, 4'b1000, 2'b11);
    run_op("and_zero",  OP_AND, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b0, 2,  32'h0000_0000, 4'b0100, 2'b00);
    run_op("orr",       OP_ORR, 32'hF0F0_0000, 32'h0000_0F0F, 1'b1, 2,  32'hF0F0_0F0F, 4'b1000, 2'b10);
    run_op("eor",       OP_EOR, 32'h0000_FF00, 32'h0000_0FF0, 1'b1, 2,  32'h0000_F0F0, 4'b0000, 2'b10);
    run_op("lsl31",     OP_LSL, 32'h0000_0001, 32'h0000_003F, 1'b1, 2,  32'h8000_0000, 4'b1000, 2'b10);
    run_op("rsv_and",   OP_RSV, 32'h0000_000C, 32'h0000_000A, 1'b1, 2,  32'h0000_0008, 4'b0000, 2'b10);
    run_op("mul_3x5",   OP_MUL, 32'd3,         32'd5,         1'b1, 34, 32'd15,        4'b0000, 2'b10);
    run_op("mul_wrap",  OP_MUL, 32'h0001_0000, 32'h0001_0000, 1'b1, 34, 32'h0000_0000, 4'b0100, 2'b10);
    run_op("mul_big",   OP_MUL, 32'h0001_0001, 32'h0000_FFFF, 1'b0, 34, 32'hFFFF_FFFF, 4'b1000, 2'b00);

    // Start held through the done pulse only: must not launch an op.
    start_op(OP_ADD, 32'd1, 32'd1, 1'b1);
    n = 0;
    while (!done && n < 100) begin @(posedge clk); #1; n++; end
    start = 1'b1; op = OP_ADD; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy || done) dones++;
      @(posedge clk); #1;
    end
    check("done_start_ignored", W'(dones), W'(0));
    check("done_start_result",  result, W'(2));

    // Start during MUL must not disturb the latched operands.
    start_op(OP_MUL, 32'd7, 32'd9, 1'b1);
    n = 0; dones = 0; seen = '0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (i == 5) begin start = 1'b1; op = OP_ADD; a = 32'd100; b = 32'd200; end
      if (i == 6) start = 1'b0;
      if (done) begin dones++; n = i; seen = result; end
    end
    check("mulbusy_dones", W'(dones), W'(1));
    check("mulbusy_lat",   W'(n), W'(34));
    check("mulbusy_res",   seen, W'(63));

    // Reset in the middle of a multiply aborts it.
    start_op(OP_MUL, 32'd5, 32'd5, 1'b1);
    repeat (9) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    check("abort_busy",   W'(busy), W'(0));
    check("abort_done",   W'(done), W'(0));
    check("abort_result", result, W'(0));
    check("abort_flags",  W'(flags), W'(0));
    check("abort_fw",     W'(flag_w), W'(0));
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    check("abort_no_done", W'(dones), W'(0));
    run_op("add_after_rst", OP_ADD, 32'd2, 32'd2, 1'b1, 2, 32'd4, 4'b0000, 2'b11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
- Execution-stage ALU that sits directly upstream of the ALU flags register.
- Accepts an operation with a start/busy/done handshake and computes a WIDTH-bit result plus NZCV flags.
- ADD/SUB/AND/ORR/EOR/LSL complete in one execute cycle. MUL is an iterative shift-add over WIDTH cycles.
- Drives flags[3:0] = {N,Z,C,V} and flag_w[1:0] in the format the flags register consumes.

Parameters:
- WIDTH, 32, operand/result width (>= 4).
- CNT_W, $clog2(WIDTH)+1, multiply iteration counter width.

Ports:
- clk        input   1        rising-edge clock
- rst        input   1        reset, synchronous, active-low (asserted when 0)
- start      input   1        request; sampled only in IDLE
- op         input   3        000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MUL, 110 LSL (by b[4:0]), 111 reserved (treated as AND)
- a          input   WIDTH    operand A
- b          input   WIDTH    operand B
- set_flags  input   1        request a flag update for this op
- busy       output  1        high from the cycle after start is accepted until done
- done       output  1        one-cycle pulse; result/flags valid
- result     output  WIDTH    held from done until the next accepted start
- flags      output  4        {N,Z,C,V}, held like result
- flag_w     output  2        [1]=update N/Z, [0]=update C/V; nonzero only while done=1

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE; busy=0, done=0, result=0, flags=0000, flag_w=00; counter and internal registers cleared.
  - Reset during EXEC or MUL aborts the operation; no done pulse is produced.
- FSM states: IDLE, EXEC, MUL, DONE.
- IDLE:
  - start=1 latches a, b, op, set_flags.
  - Goes to MUL if op==MUL (counter=0, accumulator=0); otherwise goes to EXEC.
- EXEC:
  - Computes result and flags in one cycle, then goes to DONE.
- MUL:
  - Each cycle: if multiplier LSB=1, acc += multiplicand. Then multiplicand <<= 1 and multiplier >>= 1; counter++.
  - After WIDTH iterations, goes to DONE.
  - Result is the low WIDTH bits of the product.
- DONE:
  - done=1 and flag_w is valid for exactly one cycle, then return to IDLE.
  - A start seen in the DONE cycle is ignored; it must be reasserted in IDLE.
- Latency, with start accepted at edge k:
  - Non-MUL: done is high after edge k+2.
  - MUL: done is high after edge k+WIDTH+2.
- busy=1 in EXEC and MUL, 0 in IDLE and DONE. start while busy is ignored and the latched operands are unaffected.
- Flags:
  - N = result[WIDTH-1]; Z = (result==0).
  - ADD: C = carry out of a WIDTH+1-bit sum; V = (a[msb]==b[msb]) && (result[msb]!=a[msb]).
  - SUB: C = no borrow (a >= b unsigned); V = (a[msb]!=b[msb]) && (result[msb]!=a[msb]).
  - Logical ops, LSL, MUL: C=0, V=0.
- flag_w during DONE:
  - set_flags=0: 00.
  - ADD/SUB: 11.
  - All other ops: 10.
- result and flags keep their last value until the next op reaches DONE.

Decomposition:
- Package alu_pkg:
  - alu_op_t enum (3-bit encodings above).
  - alu_state_t enum.
  - Flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module mul_iter: shift-add datapath with load/step/last signals. The FSM in multicycle_alu sequences it.

Test Plan:
- ADD a=0xFFFFFFFF, b=0x00000001, set_flags=1 -> done 2 cycles after start edge; result=0x00000000, flags=0110, flag_w=11.
- SUB a=0x80000000, b=0x00000001, set_flags=1 -> result=0x7FFFFFFF, flags=0011, flag_w=11; SUB 5-7 -> result=0xFFFFFFFE, flags=1000.
- MUL a=3, b=5 -> busy for 33 cycles, done at edge k+34; result=15, flags=0000, flag_w=10. MUL 0x10000 x 0x10000 -> result=0, flags=0100.
- AND a=0xF0F0F0F0, b=0x0F0F0F0F, set_flags=0 -> result=0, flags=0100, flag_w=00; flag_w is 00 on every non-done cycle.
- Start MUL, pulse start with ADD operands at cycle 5 -> ignored; MUL result correct; exactly one done pulse.
- Start MUL, drive rst=0 for one edge at cycle 10 -> busy=0, done never pulses, outputs zero; a new ADD 2+2 then gives 4 with flags=0000.
